// File: rtl/ifq_fetch_queue.sv
// Instruction fetch queue: DEPTH-entry {pc, instr} FIFO between fetch and decode.
// Optional same-cycle forwarding into an empty queue is enabled by defining IFQ_BYPASS_EN.
module ifq_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h00003000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [31:0]                in_instr,
    input  logic [31:0]                in_pc,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [31:0]                out_instr,
    output logic [31:0]                out_pc,
    input  logic                       out_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] C_ZERO = CW'(0);
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [AW-1:0] P_ONE  = AW'(1);

    logic [63:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_bypass;
    logic w_has_entry;
    logic w_wr;
    logic w_rd;

`ifdef IFQ_BYPASS_EN
    assign w_bypass = (r_count == C_ZERO) & in_valid & ~flush;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_has_entry = (r_count != C_ZERO);
    assign in_ready    = (r_count != C_FULL);
    assign out_valid   = w_has_entry | w_bypass;
    assign count       = r_count;

    // A forwarded entry taken by decode in the same cycle is never stored.
    assign w_wr = in_valid & in_ready & ~(w_bypass & out_ready);
    assign w_rd = w_has_entry & out_ready;

    // Head presentation: forwarded pair, stored head, or nop at RESET_PC.
    always_comb begin
        out_instr = 32'h00000000;
        out_pc    = RESET_PC;
        if (w_bypass) begin
            out_instr = in_instr;
            out_pc    = in_pc;
        end else if (w_has_entry) begin
            out_instr = r_mem[r_rd_ptr][31:0];
            out_pc    = r_mem[r_rd_ptr][63:32];
        end else begin
            out_instr = 32'h00000000;
            out_pc    = RESET_PC;
        end
    end

    // Storage write; contents are deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (w_wr && !flush) begin
            r_mem[r_wr_ptr] <= {in_pc, in_instr};
        end
    end

    // Pointer and occupancy update; flush overrides any push or pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= C_ZERO;
        end else if (flush) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= C_ZERO;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + P_ONE;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + P_ONE;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + C_ONE;
                2'b01:   r_count <= r_count - C_ONE;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
